// File: rtl/cardinal_nic_fifo_if.sv
// Processor register port and network handshake signals of the NIC.
// The DUT attaches through the slave modport; the driving side uses master.
interface cardinal_nic_fifo_if #(
  parameter int DATA_W = 64
);
  logic [0:1]        addr_nic;
  logic              nicEn;
  logic              nicWrEn;
  logic [0:DATA_W-1] d_in_nic;
  logic [0:DATA_W-1] d_out_nic;
  logic              net_si;
  logic              net_ri;
  logic [0:DATA_W-1] net_di;
  logic              net_so;
  logic              net_ro;
  logic [0:DATA_W-1] net_do;

  modport slave (
    input  addr_nic, nicEn, nicWrEn, d_in_nic, net_si, net_di, net_ro,
    output d_out_nic, net_ri, net_so, net_do
  );

  modport master (
    output addr_nic, nicEn, nicWrEn, d_in_nic, net_si, net_di, net_ro,
    input  d_out_nic, net_ri, net_so, net_do
  );
endinterface

// File: rtl/cardinal_nic_fifo.sv
// Network interface card: an IN FIFO (network -> processor) and an OUT FIFO
// (processor -> network), both exposed through a 4-register processor port.
module cardinal_nic_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cardinal_nic_fifo_if.slave   nic
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = '0;

  logic [0:DATA_W-1] r_in_mem  [DEPTH];
  logic [0:DATA_W-1] r_out_mem [DEPTH];
  logic [PTR_W-1:0]  r_in_wr_ptr, r_in_rd_ptr, r_out_wr_ptr, r_out_rd_ptr;
  logic [CNT_W-1:0]  r_in_cnt, r_out_cnt;
  logic              r_err_unf, r_err_ovf;

  logic w_rd, w_wr;
  logic w_in_rd, w_in_push, w_in_pop, w_unf_set;
  logic w_out_wr, w_out_push, w_out_pop, w_ovf_set;
  logic w_stat_clr, w_in_empty, w_out_empty;
  logic [0:DATA_W-1] w_in_stat, w_out_stat, w_dout;

  // Every full/empty decision below is taken from the pre-edge counts.
  assign w_rd        = nic.nicEn & ~nic.nicWrEn;
  assign w_wr        = nic.nicEn &  nic.nicWrEn;
  assign w_in_empty  = (r_in_cnt  == ZERO_CNT);
  assign w_out_empty = (r_out_cnt == ZERO_CNT);

  assign w_in_rd    = w_rd & (nic.addr_nic == 2'b00);
  assign w_in_push  = nic.net_si & nic.net_ri;
  assign w_in_pop   = w_in_rd & ~w_in_empty;
  assign w_unf_set  = w_in_rd &  w_in_empty;

  assign w_out_wr   = w_wr & (nic.addr_nic == 2'b10);
  assign w_out_push = w_out_wr & (r_out_cnt != FULL_CNT);
  assign w_ovf_set  = w_out_wr & (r_out_cnt == FULL_CNT);
  assign w_out_pop  = nic.net_so & nic.net_ro;

  assign w_stat_clr = w_wr & (nic.addr_nic == 2'b01);

  assign nic.net_ri = reset_n & (r_in_cnt != FULL_CNT);
  assign nic.net_so = ~w_out_empty;
  assign nic.net_do = w_out_empty ? '0 : r_out_mem[r_out_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_wr_ptr  <= '0;
      r_in_rd_ptr  <= '0;
      r_in_cnt     <= '0;
      r_out_wr_ptr <= '0;
      r_out_rd_ptr <= '0;
      r_out_cnt    <= '0;
      r_err_unf    <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      if (w_in_push)  r_in_wr_ptr  <= r_in_wr_ptr  + 1'b1;
      if (w_in_pop)   r_in_rd_ptr  <= r_in_rd_ptr  + 1'b1;
      if (w_out_push) r_out_wr_ptr <= r_out_wr_ptr + 1'b1;
      if (w_out_pop)  r_out_rd_ptr <= r_out_rd_ptr + 1'b1;
      r_in_cnt  <= r_in_cnt  + CNT_W'(w_in_push)  - CNT_W'(w_in_pop);
      r_out_cnt <= r_out_cnt + CNT_W'(w_out_push) - CNT_W'(w_out_pop);
      // A new error in the same cycle as a clear wins.
      r_err_unf <= w_unf_set | (r_err_unf & ~w_stat_clr);
      r_err_ovf <= w_ovf_set | (r_err_ovf & ~w_stat_clr);
    end
  end

  // Storage is never observable while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_in_push)  r_in_mem[r_in_wr_ptr]   <= nic.net_di;
    if (w_out_push) r_out_mem[r_out_wr_ptr] <= nic.d_in_nic;
  end

  always_comb begin
    w_in_stat  = '0;
    w_out_stat = '0;
    w_in_stat[DATA_W-1]                  = ~w_in_empty;
    w_in_stat[DATA_W-1-CNT_W:DATA_W-2]   = r_in_cnt;
    w_in_stat[DATA_W-2-CNT_W]            = r_err_unf;
    w_out_stat[DATA_W-1]                 = (r_out_cnt == FULL_CNT);
    w_out_stat[DATA_W-1-CNT_W:DATA_W-2]  = r_out_cnt;
    w_out_stat[DATA_W-2-CNT_W]           = r_err_ovf;
  end

  always_comb begin
    w_dout = '0;
    if (reset_n && w_rd) begin
      case (nic.addr_nic)
        2'b00:   w_dout = w_in_empty ? '0 : r_in_mem[r_in_rd_ptr];
        2'b01:   w_dout = w_in_stat;
        2'b11:   w_dout = w_out_stat;
        default: w_dout = '0;
      endcase
    end
  end

  assign nic.d_out_nic = w_dout;

endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// Directed and random checks of cardinal_nic_fifo against a queue-based model.
module tb_cardinal_nic_fifo;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cardinal_nic_fifo_if #(.DATA_W(DW)) nic_if ();

  cardinal_nic_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .nic     (nic_if.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_q[$];
  bit unf = 0, ovf = 0;
  logic [DW-1:0] last_dout, last_do;

  // Status word as a number: index DATA_W-1-k of the [0:DATA_W-1] bus is value bit k.
  function automatic logic [DW-1:0] stat(bit flag, int cnt, bit err);
    return DW'(flag) | (DW'(cnt) << 1) | (DW'(err) << (CNT_W + 1));
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic si, input logic [DW-1:0] di, input logic en,
                       input logic wr, input logic [1:0] ad, input logic [DW-1:0] din,
                       input logic ro);
    nic_if.net_si   = si;
    nic_if.net_di   = di;
    nic_if.nicEn    = en;
    nic_if.nicWrEn  = wr;
    nic_if.addr_nic = ad;
    nic_if.d_in_nic = din;
    nic_if.net_ro   = ro;
  endtask

  task automatic cyc(input logic si, input logic [DW-1:0] di, input logic en,
                     input logic wr, input logic [1:0] ad, input logic [DW-1:0] din,
                     input logic ro);
    logic [DW-1:0] exp_dout;
    int in_n, out_n;
    bit rd, set_unf, set_ovf, clr;
    @(negedge clk);
    drive(si, di, en, wr, ad, din, ro);
    #1;
    in_n  = in_q.size();
    out_n = out_q.size();
    rd = en && !wr;
    exp_dout = '0;
    if (rd) begin
      case (ad)
        2'd0:    exp_dout = (in_n != 0) ? in_q[0] : '0;
        2'd1:    exp_dout = stat(in_n != 0, in_n, unf);
        2'd3:    exp_dout = stat(out_n == DEPTH, out_n, ovf);
        default: exp_dout = '0;
      endcase
    end
    chk("net_ri", DW'(nic_if.net_ri), DW'(in_n != DEPTH));
    chk("net_so", DW'(nic_if.net_so), DW'(out_n != 0));
    chk("net_do", nic_if.net_do, (out_n != 0) ? out_q[0] : '0);
    chk("d_out_nic", nic_if.d_out_nic, exp_dout);
    last_dout = nic_if.d_out_nic;
    last_do   = nic_if.net_do;
    set_unf = rd && ad == 2'd0 && in_n == 0;
    set_ovf = en && wr && ad == 2'd2 && out_n == DEPTH;
    clr     = en && wr && ad == 2'd1;
    if (rd && ad == 2'd0 && in_n > 0) void'(in_q.pop_front());
    if (si && in_n < DEPTH) in_q.push_back(di);
    if (ro && out_n > 0) void'(out_q.pop_front());
    if (en && wr && ad == 2'd2 && out_n < DEPTH) out_q.push_back(din);
    unf = set_unf | (unf & !clr);
    ovf = set_ovf | (ovf & !clr);
    @(posedge clk);
  endtask

  task automatic idle();
    cyc(0, '0, 0, 0, 2'd0, '0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a [4];
    logic [DW-1:0] b [5];
    logic [DW-1:0] w;
    for (int i = 0; i < 4; i++) a[i] = 64'hA000_0000_0000_0001 + DW'(i);
    for (int i = 0; i < 5; i++) b[i] = 64'hB000_0000_0000_0001 + DW'(i);

    drive(0, '0, 1, 0, 2'd1, '0, 0);
    #12;
    chk("rst_net_ri", DW'(nic_if.net_ri), '0);
    chk("rst_net_so", DW'(nic_if.net_so), '0);
    chk("rst_net_do", nic_if.net_do, '0);
    chk("rst_dout", nic_if.d_out_nic, '0);
    @(negedge clk);
    reset_n = 1'b1;
    idle();

    // Fill IN, read status, drain, underflow
    for (int i = 0; i < 4; i++) cyc(1, a[i], 0, 0, 2'd0, '0, 0);
    cyc(0, '0, 1, 0, 2'd1, '0, 0);
    chk("in_stat_full", last_dout, 64'd9);
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 1, 0, 2'd0, '0, 0);
      chk("in_order", last_dout, a[i]);
    end
    cyc(0, '0, 1, 0, 2'd0, '0, 0);
    chk("in_unf_data", last_dout, '0);
    cyc(0, '0, 1, 0, 2'd1, '0, 0);
    chk("in_stat_unf", last_dout, 64'd16);
    cyc(0, '0, 1, 1, 2'd1, '0, 0);

    // Overflow OUT, clear, drain
    for (int i = 0; i < 5; i++) cyc(0, '0, 1, 1, 2'd2, b[i], 0);
    cyc(0, '0, 1, 0, 2'd3, '0, 0);
    chk("out_stat_ovf", last_dout, 64'd25);
    cyc(0, '0, 1, 1, 2'd1, '0, 0);
    cyc(0, '0, 1, 0, 2'd3, '0, 0);
    chk("out_stat_clr", last_dout, 64'd9);
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 0, 0, 2'd0, '0, 1);
      chk("out_drain", last_do, b[i]);
    end

    // Full OUT: write and network pop in the same cycle
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 1, 2'd2, b[i], 0);
    cyc(0, '0, 1, 1, 2'd2, b[4], 1);
    cyc(0, '0, 1, 0, 2'd3, '0, 0);
    chk("out_full_popwr", last_dout, 64'd22);
    for (int i = 1; i < 4; i++) begin
      cyc(0, '0, 0, 0, 2'd0, '0, 1);
      chk("out_after_drop", last_do, b[i]);
    end
    cyc(0, '0, 1, 1, 2'd1, '0, 0);

    // IN at count 2, concurrent push and pop across pointer wrap
    cyc(1, 64'hC0, 0, 0, 2'd0, '0, 0);
    cyc(1, 64'hC1, 0, 0, 2'd0, '0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 64'hC2 + DW'(i), 1, 0, 2'd0, '0, 0);
      chk("in_wrap_order", last_dout, 64'hC0 + DW'(i));
    end
    cyc(0, '0, 1, 0, 2'd1, '0, 0);
    chk("in_wrap_stat", last_dout, 64'd5);
    cyc(0, '0, 1, 0, 2'd0, '0, 0);
    cyc(0, '0, 1, 0, 2'd0, '0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      w = {$urandom, $urandom};
      cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), w,
          1'($urandom_range(0, 1)));
    end

    // Reset with both FIFOs at count 3
    while (in_q.size() > 0) cyc(0, '0, 1, 0, 2'd0, '0, 0);
    while (out_q.size() > 0) cyc(0, '0, 0, 0, 2'd0, '0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 64'hD0 + DW'(i), 1, 1, 2'd2, 64'hE0 + DW'(i), 0);
    @(negedge clk);
    drive(1, 64'hF0, 1, 0, 2'd0, '0, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_net_ri", DW'(nic_if.net_ri), '0);
    chk("mid_rst_net_so", DW'(nic_if.net_so), '0);
    chk("mid_rst_net_do", nic_if.net_do, '0);
    chk("mid_rst_dout", nic_if.d_out_nic, '0);
    in_q.delete();
    out_q.delete();
    unf = 0;
    ovf = 0;
    @(negedge clk);
    drive(0, '0, 0, 0, 2'd0, '0, 0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_net_ri", DW'(nic_if.net_ri), 64'd1);
    chk("post_rst_net_so", DW'(nic_if.net_so), '0);
    cyc(0, '0, 1, 0, 2'd1, '0, 0);
    chk("post_rst_in_stat", last_dout, '0);
    cyc(0, '0, 1, 0, 2'd3, '0, 0);
    chk("post_rst_out_stat", last_dout, '0);
    cyc(1, 64'h1234, 0, 0, 2'd0, '0, 0);
    cyc(0, '0, 1, 0, 2'd0, '0, 0);
    chk("post_rst_first", last_dout, 64'h1234);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cardinal_nic_fifo.md
CARDINAL_NIC_FIFO -- requirements
Module: cardinal_nic_fifo

Interface
REQ-001 Parameter DATA_W, default 64, width of every data word and of the processor/network data buses.
REQ-002 Parameter DEPTH, default 4, entries per FIFO; power of two, >=2; CNT_W = log2(DEPTH)+1.
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 addr_nic  input  [0:1]  register select: 00 in-data, 01 in-status, 10 out-data, 11 out-status.
REQ-007 nicEn  input  1  processor access strobe.
REQ-008 nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn.
REQ-009 d_in_nic  input  [0:DATA_W-1]  processor write data.
REQ-010 d_out_nic  output  [0:DATA_W-1]  processor read data, combinational.
REQ-011 net_si  input  1  network offers word to input FIFO.
REQ-012 net_ri  output  1  input FIFO can accept.
REQ-013 net_di  input  [0:DATA_W-1]  network input word.
REQ-014 net_so  output  1  output FIFO holds a word for network.
REQ-015 net_ro  input  1  network accepts output word.
REQ-016 net_do  output  [0:DATA_W-1]  output FIFO head word.

Function
REQ-017 Two independent circular FIFOs (IN: network->processor; OUT: processor->network), DEPTH entries each, read/write pointers wrap modulo DEPTH, occupancy counters 0..DEPTH.
REQ-018 IN push: net_si & net_ri at clock edge writes net_di; net_ri = reset_n & (in_count != DEPTH).
REQ-019 IN pop: nicEn & !nicWrEn & addr_nic==00 & in_count!=0 pops head at clock edge; d_out_nic shows pre-pop head that cycle.
REQ-020 OUT push: nicEn & nicWrEn & addr_nic==10 & out_count!=DEPTH writes d_in_nic.
REQ-021 OUT pop: net_so & net_ro at clock edge; net_so = (out_count!=0); net_do = OUT head, 0 when empty.
REQ-022 Simultaneous push and pop on one FIFO both execute; count unchanged; legal at any count 1..DEPTH-1, and at full/empty per full/empty flags sampled before the edge.
REQ-023 Full/empty decisions use pre-edge counts: OUT write when full is dropped even if network pops in the same cycle.
REQ-024 Sticky err_ovf: set by dropped OUT write (REQ-023); sticky err_unf: set by in-data read when IN empty (no pop, d_out_nic = 0).
REQ-025 Write to addr 01 clears both error flags (set-wins if a new error occurs same cycle); writes to 00 and 11 ignored.
REQ-026 Read 01 returns: bit DATA_W-1 = in_count!=0; bits [DATA_W-1-CNT_W : DATA_W-2] = in_count; bit DATA_W-2-CNT_W = err_unf; others 0.
REQ-027 Read 11 returns: bit DATA_W-1 = out_count==DEPTH; bits [DATA_W-1-CNT_W : DATA_W-2] = out_count; bit DATA_W-2-CNT_W = err_ovf; others 0.
REQ-028 Read 10, any write, or nicEn=0: d_out_nic = 0.
REQ-029 Status reads have no side effects.

Reset
REQ-030 reset_n low: both counts and pointers 0, errors 0, net_so 0, net_ri 0, net_do 0, d_out_nic 0, immediately (asynchronous).
REQ-031 Reset mid-operation discards all buffered words; first legal push after reset_n rises lands at pointer 0.
REQ-032 FIFO storage contents need not be reset; never observable while empty.

Verification
REQ-033 Network pushes A1..A4 (DEPTH=4) -> net_ri drops after 4th; status 01 reads count 4, flag 1; four in-data reads return A1..A4 in order; fifth read returns 0, err_unf=1.
REQ-034 Processor writes B1..B5 with net_ro=0 -> 5th dropped, status 11 shows count 4, full 1, err_ovf 1; write addr 01 -> err_ovf 0; net_ro=1 drains B1..B4 in four cycles.
REQ-035 OUT full, same-cycle processor write B5 and network pop -> B5 dropped, count 3, err_ovf 1.
REQ-036 IN at count 2, same-cycle net push and processor pop -> count stays 2, order preserved across pointer wrap (run 10 words).
REQ-037 reset_n asserted with both FIFOs at count 3 -> all outputs 0 same cycle; after release net_ri=1, net_so=0, statuses read 0.
